// File: rtl/data_in.sv
// data_in: input-port receiver for one router link.
//
// Accepts flits from the upstream sender over a zero-latency req/ack handshake into a
// 4-entry FIFO. A head flit at the FIFO front is XY-routed, the port request is raised to
// the switch allocator, and once granted the packet streams to the crossbar until its tail.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_data    flit offered by the upstream sender
//   in_req     upstream write request (in_data valid)
//   in_ack     write acknowledge, flit taken at this edge (combinational)
//   fifo_count FIFO occupancy 0..4
//   sw_req     one-hot {L,S,N,W,E} request to the switch allocator (bit0 = E)
//   sw_grant   allocator grant for this input
//   out_data   flit to the crossbar ({2'b11, zeros} when not valid)
//   out_valid  out_data is valid
//   out_ready  crossbar accepts the flit
//   drop_err   one-cycle pulse per discarded orphan flit
module data_in #(
    parameter int unsigned LL     = 16,
    parameter int unsigned MM     = 2,
    parameter int unsigned X_ADDR = 0,
    parameter int unsigned Y_ADDR = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [LL-1:0] in_data,
    input  logic          in_req,
    output logic          in_ack,
    output logic [2:0]    fifo_count,
    output logic [4:0]    sw_req,
    input  logic          sw_grant,
    output logic [LL-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          drop_err
);

    typedef enum logic [1:0] {StIdle, StRoute, StRequest, StForward} state_e;

    localparam logic [1:0]    TypeHead = 2'b00;
    localparam logic [1:0]    TypeTail = 2'b10;
    localparam logic [1:0]    TypeIdle = 2'b11;
    localparam logic [MM-1:0] XA       = MM'(X_ADDR);
    localparam logic [MM-1:0] YA       = MM'(Y_ADDR);

    logic [LL-1:0] mem_q [4];
    logic [1:0]    wr_ptr_q, wr_ptr_d;
    logic [1:0]    rd_ptr_q, rd_ptr_d;
    logic [2:0]    count_q, count_d;
    state_e        state_q, state_d;
    logic [4:0]    route_q, route_d;
    logic          drop_q, drop_d;

    logic [LL-1:0] front;
    logic [1:0]    front_type;
    logic [MM-1:0] dx, dy;
    logic [4:0]    xy_route;
    logic          not_empty, full, push, pop;

    assign front      = mem_q[rd_ptr_q];
    assign front_type = front[LL-1:LL-2];
    assign dx         = front[LL-3 -: MM];
    assign dy         = front[LL-3-MM -: MM];
    assign not_empty  = (count_q != 3'd0);
    assign full       = (count_q == 3'd4);

    // Reset gates the ack so the sender never pops a flit while we are held in reset.
    assign in_ack     = in_req & ~full & reset;
    // Idle/invalid flits are acked but never stored.
    assign push       = in_ack & (in_data[LL-1:LL-2] != TypeIdle);
    assign fifo_count = count_q;
    assign drop_err   = drop_q;

    // Dimension-ordered route of the head flit at the FIFO front.
    always_comb begin
        xy_route = 5'b00000;
        if (dx > XA) begin
            xy_route = 5'b00001;
        end else if (dx < XA) begin
            xy_route = 5'b00010;
        end else if (dy > YA) begin
            xy_route = 5'b00100;
        end else if (dy < YA) begin
            xy_route = 5'b01000;
        end else begin
            xy_route = 5'b10000;
        end
    end

    always_comb begin
        state_d   = state_q;
        route_d   = route_q;
        drop_d    = 1'b0;
        pop       = 1'b0;
        sw_req    = 5'b00000;
        out_valid = 1'b0;
        out_data  = {TypeIdle, {(LL-2){1'b0}}};
        unique case (state_q)
            StIdle: begin
                if (not_empty) begin
                    if (front_type == TypeHead) begin
                        state_d = StRoute;
                    end else begin
                        // Body/tail with no head in front of it: discard.
                        pop    = 1'b1;
                        drop_d = 1'b1;
                    end
                end
            end
            StRoute: begin
                route_d = xy_route;
                state_d = StRequest;
            end
            StRequest: begin
                sw_req = route_q;
                if (sw_grant) begin
                    state_d = StForward;
                end
            end
            StForward: begin
                // Grant no longer matters: the output stays locked until the tail leaves.
                sw_req    = route_q;
                out_valid = not_empty;
                if (not_empty) begin
                    out_data = front;
                end
                if (not_empty && out_ready) begin
                    pop = 1'b1;
                    if (front_type == TypeTail) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            state_q  <= StIdle;
            route_q  <= 5'b00000;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            route_q  <= route_d;
            drop_q   <= drop_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule
